// File: rtl/zcode_decoder.sv
// zcode_decoder: turns a stream of 2-bit Z code symbols into bytes.
// Each symbol decodes to two data bits {X1,X2}; four symbols are packed
// MSB-first into one byte, which is queued in a small output FIFO.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high; valid must not depend on ready, and the
// producer holds its data stable until the transfer. in_ready is derived
// from registered state only, so there is no combinational path from
// out_ready or in_valid to in_ready.
module zcode_decoder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [1:0]  in_z,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    input  logic        out_ready,
    output logic [15:0] byte_cnt,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);

    // Collector state = number of symbols already held for the current byte.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [5:0]      r_acc;
    logic [1:0]      w_x;
    logic [7:0]      w_byte;
    logic            w_in_xfer;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_byte_cnt;

    // Symbol decode: X1 = Z2, X2 = ~(Z1 ^ Z2), with in_z = {Z1, Z2}.
    assign w_x    = {in_z[0], ~(in_z[1] ^ in_z[0])};
    // Earlier symbols sit in r_acc (oldest in the top bits); the current one fills [1:0].
    assign w_byte = {r_acc, w_x};

    assign w_full    = (r_count == FULL_LEVEL);
    assign w_empty   = (r_count == '0);

    // Only the last symbol of a group needs buffer space, so only S3 can stall.
    assign in_ready  = (r_state != S3) || !w_full;
    assign out_valid = !w_empty;
    assign out_byte  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign byte_cnt  = r_byte_cnt;
    assign dbg_state = r_state;

    // Flush overrides any transfer or pop on the same edge.
    assign w_in_xfer = in_valid && in_ready && !flush;
    assign w_push    = w_in_xfer && (r_state == S3);
    assign w_pop     = out_valid && out_ready && !flush;

    // Collector next state: advance one step per accepted symbol, flush returns to S0.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S0;
        end else if (w_in_xfer) begin
            case (r_state)
                S0:      w_state_nxt = S1;
                S1:      w_state_nxt = S2;
                S2:      w_state_nxt = S3;
                S3:      w_state_nxt = S0;
                default: w_state_nxt = S0;
            endcase
        end
    end

    // Collector state and partial-symbol shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_acc <= '0;
            end else if (w_in_xfer) begin
                // In S3 the shifted value is stale but gets fully overwritten by the next group.
                r_acc <= {r_acc[3:0], w_x};
            end
        end
    end

    // FIFO storage; contents are only observable while the entry is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_byte;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Popped-byte counter; survives flush, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
        end else if (w_pop) begin
            r_byte_cnt <= r_byte_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_zcode_decoder.sv
// Self-checking bench for zcode_decoder: directed scenarios plus a long
// randomized run, checked by a scoreboard fed from a symbol-level model.
module tb_zcode_decoder;

  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_z = 2'b00;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_ready = 1'b0;
  logic [15:0] byte_cnt;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  zcode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_z      (in_z),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_ready (out_ready),
    .byte_cnt  (byte_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Code table: Z=00->01, 01->10, 10->00, 11->11 (value is {X1,X2}).
  int        dec_lut [4] = '{1, 2, 0, 3};
  logic [7:0] exp_q[$];
  int        m_nsym = 0;   // symbols collected toward the current byte
  int        m_acc = 0;    // byte under construction, built as acc*4 + x
  logic [15:0] m_cnt = 16'd0;

  // Monitor: at each falling edge compare outputs with the model, then
  // apply what the coming rising edge will do to the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_nsym = 0;
      m_acc = 0;
      m_cnt = 16'd0;
    end else begin
      logic m_rdy;
      logic m_has;
      logic [7:0] e;
      m_has = (exp_q.size() != 0);
      m_rdy = !(m_nsym == 3 && exp_q.size() == DEPTH);
      chk("out_valid", {15'd0, out_valid}, {15'd0, m_has});
      chk("in_ready", {15'd0, in_ready}, {15'd0, m_rdy});
      chk("byte_cnt", byte_cnt, m_cnt);
      chk("fsm_state", {14'd0, dbg_state}, 16'(m_nsym));
      if (flush) begin
        exp_q.delete();
        m_nsym = 0;
        m_acc = 0;
      end else begin
        if (m_has && out_ready) begin
          e = exp_q.pop_front();
          chk("out_byte", {8'd0, out_byte}, {8'd0, e});
          m_cnt = m_cnt + 16'd1;
        end
        if (in_valid && m_rdy) begin
          m_acc = m_acc * 4 + dec_lut[in_z];
          m_nsym++;
          if (m_nsym == 4) begin
            exp_q.push_back(m_acc[7:0]);
            m_nsym = 0;
            m_acc = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one symbol and return #1 after the edge on which it was taken.
  task automatic send_sym(input logic [1:0] z);
    int k;
    in_valid = 1'b1;
    in_z = z;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 200) begin
        fail_now("send_sym");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_z = 2'($urandom);
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (!out_valid) break;
      k++;
      if (k > 200) begin
        fail_now("wait_empty");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check the outputs react immediately.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_byte_cnt", byte_cnt, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_byte", {8'd0, out_byte}, 16'd0);
    chk("rst_state", {14'd0, dbg_state}, 16'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic rand_done = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g [12];

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    chk("por_out_valid", {15'd0, out_valid}, 16'd0);
    chk("por_in_ready", {15'd0, in_ready}, 16'd1);
    chk("por_byte_cnt", byte_cnt, 16'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic group 10,00,01,11 -> 0x1B, visible one cycle after the 4th symbol.
    out_ready = 1'b1;
    send_sym(2'b10);
    send_sym(2'b00);
    send_sym(2'b01);
    send_sym(2'b11);
    chk("t1_valid", {15'd0, out_valid}, 16'd1);
    chk("t1_byte", {8'd0, out_byte}, 16'h1B);
    @(posedge clk);
    #1;
    chk("t1_cnt", byte_cnt, 16'd1);

    // Backpressure: 12 symbols of 11 with the consumer stalled.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_sym(2'b11);
    chk("t2_in_ready_low", {15'd0, in_ready}, 16'd0);
    chk("t2_state_s3", {14'd0, dbg_state}, 16'd3);
    chk("t2_head", {8'd0, out_byte}, 16'hFF);
    in_valid = 1'b1;
    in_z = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_still_stalled", {15'd0, in_ready}, 16'd0);
    chk("t2_state_held", {14'd0, dbg_state}, 16'd3);
    out_ready = 1'b1;
    send_sym(2'b11);
    wait_empty();
    chk("t2_cnt", byte_cnt, 16'd3);

    // Full buffer in S3: pop and the stalled push resolve on consecutive edges.
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) g[i] = 2'($urandom);
    for (int i = 0; i < 11; i++) send_sym(g[i]);
    chk("t3_in_ready_low", {15'd0, in_ready}, 16'd0);
    out_ready = 1'b1;
    send_sym(g[11]);
    wait_empty();
    chk("t3_cnt", byte_cnt, 16'd6);

    // Flush drops a buffered byte and a partial group; concurrent pop ignored.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_sym(2'($urandom));
    send_sym(2'b01);
    send_sym(2'b01);
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("t4_state_s0", {14'd0, dbg_state}, 16'd0);
    chk("t4_out_valid", {15'd0, out_valid}, 16'd0);
    chk("t4_cnt_kept", byte_cnt, 16'd6);
    for (int i = 0; i < 4; i++) send_sym(2'b00);
    chk("t4_byte", {8'd0, out_byte}, 16'h55);
    wait_empty();

    // Reset mid-group with a byte buffered, then a fresh group.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_sym(2'($urandom));
    for (int i = 0; i < 3; i++) send_sym(2'($urandom));
    do_reset();
    out_ready = 1'b1;
    send_sym(2'b01);
    send_sym(2'b10);
    send_sym(2'b01);
    send_sym(2'b10);
    chk("t5_byte", {8'd0, out_byte}, 16'h88);
    @(posedge clk);
    #1;
    chk("t5_cnt", byte_cnt, 16'd1);

    // Randomized throttling on both sides.
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_z = 2'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send_sym(2'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 99) < 60);
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();
    chk("final_cnt", byte_cnt, 16'd2501);
    chk("final_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
